line_addr_compose: RTL and testbench
====================================

# line_addr_compose

Reassembles full byte addresses from cache-line fields (tag, index, offset) and emits them as a burst of beat addresses covering one cache line. It is the inverse of the address split done on the lookup path. The cache controller issues one request per line fill or write-back, and this block drives the per-beat address stream toward the memory model. Field widths come from the shared package, so the split and the compose always agree.

## Interface
Parameters:
- BEAT_BYTES, 4: bytes per beat. Power of two, between 1 and 2^OFFSET_BITS.

Ports:
- clk  input  1  clock; all logic on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- req_valid  input  1  line request valid
- req_ready  output  1  block idle, request can be accepted
- req_tag  input  TAG_BITS  line tag
- req_index  input  INDEX_BITS  set index
- req_offset  input  OFFSET_BITS  critical byte offset; used only when wrap is enabled
- addr_valid  output  1  beat address valid
- addr_ready  input  1  downstream accepts the beat
- addr  output  ADDRESS_BITS  composed byte address, beat-aligned
- addr_last  output  1  final beat of the line
- beat_idx  output  log2(BEATS) (min 1)  beat ordinal within the burst, 0 = first

## Operation
- BEATS = 2^OFFSET_BITS / BEAT_BYTES. BSH = log2(BEAT_BYTES).
- Address layout: addr = {tag, index, offset}. The bottom BSH offset bits are always 0.
- Two-state FSM:
  - IDLE: req_ready = 1. When req_valid && req_ready, latch tag and index, compute the start beat, go to BURST.
  - BURST: present beats. A beat advances only on addr_valid && addr_ready.
  - On the handshake of the beat with addr_last = 1, return to IDLE.
- Start beat:
  - With wrap enabled: req_offset[OFFSET_BITS-1:BSH].
  - Without wrap: 0.
- Beat sequence: beat field = (start + n) mod BEATS, for n = 0 .. BEATS-1. Wraps within the line; tag and index never change.
- addr_last = 1 exactly when n = BEATS-1. beat_idx = n.
- When BEATS = 1: a single beat with addr_last = 1.
- Requests presented during BURST are not accepted (req_ready = 0). The requester holds them.
- Reset behaviour:
  - rst_n low at an edge forces IDLE, including mid-burst. The current burst is aborted and no further beats are issued.
  - Output values after that edge: addr_valid 0, addr 0, addr_last 0, beat_idx 0, req_ready 1.

## Timing
- req_ready is decoded from state only (IDLE), with no combinational path from req_valid.
- Request accepted at edge k: addr_valid = 1 from edge k (visible in cycle k+1). Latency is one cycle.
- addr_valid stays high throughout BURST. addr, addr_last and beat_idx are registered and stable while addr_valid && !addr_ready.
- With addr_ready held high: one beat per cycle, so BEATS cycles for the full burst.
- Last beat handshake at edge m: addr_valid = 0 and req_ready = 1 from edge m. The earliest next request is accepted at edge m+1, leaving one idle cycle between bursts.
- addr_ready may toggle arbitrarily. Beats are never skipped or duplicated.

## Configuration
- LINE_ADDR_COMPOSE_WRAP_EN defined:
  - Critical-word-first order, starting at the beat that contains req_offset and wrapping within the line.
- Undefined:
  - req_offset is ignored and left unconnected internally.
  - The burst always starts at offset 0 and runs in ascending order.
  - The ports are unchanged in both builds.

## Structure
- mypkg supplies ADDRESS_BITS, TAG_BITS, INDEX_BITS and OFFSET_BITS. TAG_BITS + INDEX_BITS + OFFSET_BITS = ADDRESS_BITS is checked at elaboration.
- Add to mypkg: an enum typedef for the FSM states (IDLE, BURST), and a function compose_addr(tag, index, offset) that returns ADDRESS_BITS. The lookup-side split and the bench's reference model share this function.
- No sub-module. The beat counter and FSM are small enough to stay inline.

## Test plan
Vectors use OFFSET_BITS = 6, INDEX_BITS = 5, TAG_BITS = 21 and BEAT_BYTES = 16, giving BEATS = 4.

1. Basic burst, wrap off, addr_ready = 1. Request tag 0x12345, index 0x0A → 0x091A2A80, 0x091A2A90, 0x091A2AA0, 0x091A2AB0 on consecutive cycles. addr_last is set on the fourth beat only. beat_idx runs 0..3.
2. Wrap on, same request with offset 0x28 → 0x091A2AA0, 0x091A2AB0, 0x091A2A80, 0x091A2A90. addr_last is set on 0x091A2A90.
3. Backpressure: drive addr_ready 1,0,0,1,0,1,1. Exactly four handshakes occur, in order, and addr is stable while stalled.
4. Back-to-back requests: req_valid held high with a new tag → req_ready = 0 during the burst. The second request is accepted on the edge after the last handshake, and its first beat follows after one cycle.
5. Reset mid-burst: assert rst_n low after beat 1 is accepted. On the next edge addr_valid = 0 and req_ready = 1, and no further beats are issued. A new request then starts cleanly at beat_idx 0.
6. Extremes: tag all ones, index 0x1F, offset 0x3F with wrap on → first address 0xFFFFFFF0, wrap to 0xFFFFFFC0, with no carry into index or tag.

Source files
------------

// File: rtl/mypkg.sv
// Shared address-layout package.
// Supplies the field widths used by both the lookup-side address split and
// the line-address composer, the composer FSM state type, and the
// compose_addr helper that glues {tag, index, offset} into a byte address.
package mypkg;

    localparam int unsigned ADDRESS_BITS = 32;
    localparam int unsigned TAG_BITS     = 21;
    localparam int unsigned INDEX_BITS   = 5;
    localparam int unsigned OFFSET_BITS  = 6;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    function automatic logic [ADDRESS_BITS-1:0] compose_addr(
        input logic [TAG_BITS-1:0]    tag,
        input logic [INDEX_BITS-1:0]  index,
        input logic [OFFSET_BITS-1:0] offset
    );
        return {tag, index, offset};
    endfunction

endpackage

// File: rtl/line_addr_compose.sv
// line_addr_compose
// Rebuilds a full byte address from a cache line's tag and index and emits
// one beat-aligned address per beat of the line, as a valid/ready burst.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   req_valid/req_ready   line request handshake (ready only while idle)
//   req_tag, req_index    line identity, latched when the request is taken
//   req_offset            critical byte offset (wrap build only)
//   addr_valid/addr_ready beat handshake toward the memory model
//   addr                  beat-aligned byte address
//   addr_last             set on the final beat of the line
//   beat_idx              beat ordinal within the burst, 0 = first
//
// Build option: define LINE_ADDR_COMPOSE_WRAP_EN for critical-word-first
// order (start at the beat holding req_offset, wrap within the line).
// Without it the burst always starts at offset 0 and req_offset is ignored.
module line_addr_compose
    import mypkg::*;
#(
    parameter int unsigned BEAT_BYTES = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [TAG_BITS-1:0]                   req_tag,
    input  logic [INDEX_BITS-1:0]                 req_index,
    input  logic [OFFSET_BITS-1:0]                req_offset,
    output logic                                  addr_valid,
    input  logic                                  addr_ready,
    output logic [ADDRESS_BITS-1:0]               addr,
    output logic                                  addr_last,
    output logic [((2**OFFSET_BITS)/BEAT_BYTES > 1 ?
                   $clog2((2**OFFSET_BITS)/BEAT_BYTES) : 1)-1:0] beat_idx
);

    localparam int unsigned BSH   = $clog2(BEAT_BYTES);
    localparam int unsigned BEATS = (2**OFFSET_BITS) / BEAT_BYTES;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (TAG_BITS + INDEX_BITS + OFFSET_BITS != ADDRESS_BITS) begin : g_bad_layout
        $error("line_addr_compose: TAG_BITS + INDEX_BITS + OFFSET_BITS != ADDRESS_BITS");
    end
    if (BEAT_BYTES == 0 || (BEAT_BYTES & (BEAT_BYTES - 1)) != 0 ||
        BEAT_BYTES > 2**OFFSET_BITS) begin : g_bad_beat
        $error("line_addr_compose: BEAT_BYTES must be a power of two within one line");
    end

    state_t                  state;
    logic [TAG_BITS-1:0]     tag_q;
    logic [INDEX_BITS-1:0]   index_q;
    logic [BW-1:0]           beat_q;     // beat field of the address on display
    logic [BW-1:0]           start_beat;
    logic [BW-1:0]           next_beat;

    // Beat number -> byte offset within the line; low BSH bits are always 0.
    // With a single beat the shift clears the whole field.
    function automatic logic [OFFSET_BITS-1:0] beat_off(input logic [BW-1:0] b);
        return OFFSET_BITS'(b) << BSH;
    endfunction

`ifdef LINE_ADDR_COMPOSE_WRAP_EN
    assign start_beat = BW'(req_offset >> BSH);
`else
    logic unused_offset;
    assign unused_offset = ^req_offset;
    assign start_beat    = '0;
`endif

    // Power-of-two beat count, so the BW-bit add is the mod-BEATS wrap.
    assign next_beat = beat_q + BW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            addr_valid <= 1'b0;
            addr       <= '0;
            addr_last  <= 1'b0;
            beat_idx   <= '0;
            tag_q      <= '0;
            index_q    <= '0;
            beat_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tag_q      <= req_tag;
                        index_q    <= req_index;
                        beat_q     <= start_beat;
                        addr       <= compose_addr(req_tag, req_index, beat_off(start_beat));
                        addr_valid <= 1'b1;
                        addr_last  <= (BEATS == 1);
                        beat_idx   <= '0;
                        req_ready  <= 1'b0;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (addr_ready) begin
                        if (addr_last) begin
                            addr_valid <= 1'b0;
                            addr_last  <= 1'b0;
                            beat_idx   <= '0;
                            req_ready  <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            beat_q    <= next_beat;
                            addr      <= compose_addr(tag_q, index_q, beat_off(next_beat));
                            beat_idx  <= beat_idx + BW'(1);
                            addr_last <= (32'(beat_idx) + 32'd2 == BEATS);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    addr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_addr_compose.sv
module tb_line_addr_compose;
    import mypkg::*;

    localparam int BB = 16;
    localparam int NB = (2**OFFSET_BITS) / BB;

`ifdef LINE_ADDR_COMPOSE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    req_valid;
    logic                    req_ready;
    logic [TAG_BITS-1:0]     req_tag;
    logic [INDEX_BITS-1:0]   req_index;
    logic [OFFSET_BITS-1:0]  req_offset;
    logic                    addr_valid;
    logic                    addr_ready;
    logic [ADDRESS_BITS-1:0] addr;
    logic                    addr_last;
    logic [1:0]              beat_idx;

    always #5 clk = ~clk;

    line_addr_compose #(.BEAT_BYTES(BB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_tag    (req_tag),
        .req_index  (req_index),
        .req_offset (req_offset),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .addr       (addr),
        .addr_last  (addr_last),
        .beat_idx   (beat_idx)
    );

    typedef struct {
        logic [31:0] a;
        logic        last;
        logic [1:0]  idx;
    } beat_t;

    beat_t       expq[$];
    beat_t       constq[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] pat;
    int          pat_len;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: line base plus ((start + n) mod beats) * beat size.
    task automatic model(input logic [20:0] t, input logic [4:0] ix, input logic [5:0] of);
        logic [31:0] base;
        int          start;
        beat_t       b;
        expq.delete();
        base  = compose_addr(t, ix, '0);
        start = WRAP ? int'(of) / BB : 0;
        for (int n = 0; n < NB; n++) begin
            b.a    = base + 32'(((start + n) % NB) * BB);
            b.last = (n == NB - 1);
            b.idx  = 2'(n);
            expq.push_back(b);
        end
    endtask

    task automatic push_c(input logic [31:0] a, input logic last, input logic [1:0] idx);
        beat_t b;
        b.a = a; b.last = last; b.idx = idx;
        constq.push_back(b);
    endtask

    // mode: 0 = ready always high, 1 = random ready, 2 = fixed pattern (pat/pat_len)
    task automatic burst(input logic [20:0] t, input logic [4:0] ix, input logic [5:0] of,
                         input int mode, input bit use_const, input bit pre_acc,
                         input bit hold_next, input logic [20:0] nt, input logic [4:0] nix);
        int          cyc;
        int          hs;
        bit          done;
        bit          stalled;
        logic [31:0] prev_a;
        beat_t       e;
        if (use_const) expq = constq;
        else           model(t, ix, of);
        if (!pre_acc) begin
            @(negedge clk);
            req_tag = t; req_index = ix; req_offset = of; req_valid = 1'b1;
            cyc = 0;
            while (!req_ready && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            check("req_ready_idle", 32'(req_ready), 32'd1);
            @(posedge clk);
            @(negedge clk);
            if (hold_next) begin
                req_tag = nt; req_index = nix;
            end else begin
                req_valid = 1'b0;
            end
            check("first_valid_latency", 32'(addr_valid), 32'd1);
        end
        cyc = 0; hs = 0; done = 0; stalled = 0; prev_a = '0;
        while (!done && cyc < 200) begin
            if (stalled) check("stall_stable", addr, prev_a);
            check("busy_req_ready", 32'(req_ready), 32'd0);
            check("busy_addr_valid", 32'(addr_valid), 32'd1);
            case (mode)
                0:       addr_ready = 1'b1;
                1:       addr_ready = 1'($urandom_range(0, 1));
                default: addr_ready = (cyc < pat_len) ? pat[cyc] : 1'b1;
            endcase
            if (addr_ready) begin
                if (expq.size() == 0) begin
                    check("extra_beat", 32'd1, 32'd0);
                    done = 1;
                end else begin
                    e = expq.pop_front();
                    check("addr", addr, e.a);
                    check("addr_last", 32'(addr_last), 32'(e.last));
                    check("beat_idx", 32'(beat_idx), 32'(e.idx));
                    hs++;
                    if (hs == NB) done = 1;
                end
            end
            stalled = !addr_ready;
            prev_a  = addr;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (!done) check("burst_timeout", 32'd0, 32'd1);
        if (mode == 0) check("burst_cycles", 32'(cyc), 32'(NB));
        if (mode == 2) check("pattern_cycles", 32'(cyc), 32'(pat_len));
        addr_ready = 1'b0;
        check("after_last_valid", 32'(addr_valid), 32'd0);
        check("after_last_ready", 32'(req_ready), 32'd1);
        if (hold_next) begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            check("b2b_valid", 32'(addr_valid), 32'd1);
            check("b2b_idx", 32'(beat_idx), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_tag = '0; req_index = '0;
        req_offset = '0; addr_ready = 1'b0; pat = '0; pat_len = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_addr_valid", 32'(addr_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_addr", addr, 32'd0);
        check("rst_addr_last", 32'(addr_last), 32'd0);
        check("rst_beat_idx", 32'(beat_idx), 32'd0);
        rst_n = 1'b1;

        // Basic / wrapped burst with known addresses
        constq.delete();
        if (WRAP) begin
            push_c(32'h091A2AA0, 0, 0); push_c(32'h091A2AB0, 0, 1);
            push_c(32'h091A2A80, 0, 2); push_c(32'h091A2A90, 1, 3);
        end else begin
            push_c(32'h091A2A80, 0, 0); push_c(32'h091A2A90, 0, 1);
            push_c(32'h091A2AA0, 0, 2); push_c(32'h091A2AB0, 1, 3);
        end
        burst(21'h12345, 5'h0A, 6'h28, 0, 1, 0, 0, '0, '0);

        // Backpressure pattern 1,0,0,1,0,1,1
        pat = 16'b1101001; pat_len = 7;
        burst(21'h12345, 5'h0A, 6'h28, 2, 0, 0, 0, '0, '0);

        // Back-to-back: second request held during the first burst
        burst(21'h0ABCD, 5'h03, 6'h10, 0, 0, 0, 1, 21'h1F00F, 5'h11);
        burst(21'h1F00F, 5'h11, 6'h10, 0, 0, 1, 0, '0, '0);

        // Reset mid-burst after beat 1 handshake
        @(negedge clk);
        req_tag = 21'h00777; req_index = 5'h05; req_offset = 6'h00; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; addr_ready = 1'b1;
        check("rstmid_beat0", 32'(beat_idx), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rstmid_beat1", 32'(beat_idx), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_addr_valid", 32'(addr_valid), 32'd0);
        check("rstmid_req_ready", 32'(req_ready), 32'd1);
        check("rstmid_addr", addr, 32'd0);
        check("rstmid_addr_last", 32'(addr_last), 32'd0);
        check("rstmid_beat_idx", 32'(beat_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid_no_beats", 32'(addr_valid), 32'd0);
        end
        addr_ready = 1'b0;
        burst(21'h00778, 5'h06, 6'h30, 0, 0, 0, 0, '0, '0);

        // Extremes: no carry out of the offset field
        constq.delete();
        if (WRAP) begin
            push_c(32'hFFFFFFF0, 0, 0); push_c(32'hFFFFFFC0, 0, 1);
            push_c(32'hFFFFFFD0, 0, 2); push_c(32'hFFFFFFE0, 1, 3);
        end else begin
            push_c(32'hFFFFFFC0, 0, 0); push_c(32'hFFFFFFD0, 0, 1);
            push_c(32'hFFFFFFE0, 0, 2); push_c(32'hFFFFFFF0, 1, 3);
        end
        burst(21'h1FFFFF, 5'h1F, 6'h3F, 1, 1, 0, 0, '0, '0);

        // Randomized requests against the model
        for (int r = 0; r < 20; r++) begin
            burst(21'($urandom), 5'($urandom), 6'($urandom),
                  int'($urandom_range(0, 1)), 0, 0, 0, '0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
